// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator CPU.
// Optional build macro ILLEGAL_TRAP_EN: opcodes 8-E halt the core and set the sticky illegal flag.
module cpu_control_unit #(
  parameter logic [7:0] RESET_PC    = 8'h00,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] from_memory,
  input  logic       zero,
  output logic [7:0] address,
  output logic       write,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic [7:0] pc,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [2:0] {
    StF0, StF1, StO0, StO1, StM0, StM1, StSt, StHalt
  } state_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpAdd = 4'h3;
  localparam logic [3:0] OpSub = 4'h4;
  localparam logic [3:0] OpJmp = 4'h5;
  localparam logic [3:0] OpJz  = 4'h6;
  localparam logic [3:0] OpLdi = 4'h7;

  localparam logic [1:0] AluPass = 2'b00;
  localparam logic [1:0] AluAdd  = 2'b01;
  localparam logic [1:0] AluSub  = 2'b10;

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opr_q, opr_d;
  // Only the opcode nibble of IR is kept; the low nibble carries no meaning.
  logic [3:0] ir_q, ir_d;
  logic [3:0] op_fetch;

  assign op_fetch = from_memory[7:4];
  assign pc       = pc_q;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    opr_d    = opr_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    address  = pc_q;
    write    = 1'b0;
    acc_load = 1'b0;
    alu_op   = AluPass;
    halted   = 1'b0;

    unique case (state_q)
      StF0: state_d = StF1;
      StF1: begin
        ir_d = op_fetch;
        pc_d = pc_q + 8'd1;
        if (op_fetch == HALT_OPCODE) begin
          state_d = StHalt;
        end else if (op_fetch == OpNop) begin
          state_d = StF0;
        end else if (op_fetch <= OpLdi) begin
          state_d = StO0;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d   = StHalt;
          illegal_d = 1'b1;
`else
          state_d   = StF0;
`endif
        end
      end
      StO0: state_d = StO1;
      StO1: begin
        opr_d   = from_memory;
        pc_d    = pc_q + 8'd1;
        state_d = StF0;
        case (ir_q)
          OpLdi: acc_load = 1'b1;
          OpJmp: pc_d = from_memory;
          OpJz:  if (zero) pc_d = from_memory;
          OpLda, OpAdd, OpSub: state_d = StM0;
          OpSta: state_d = StSt;
          default: ;
        endcase
      end
      StM0: begin
        address = opr_q;
        state_d = StM1;
      end
      StM1: begin
        address  = opr_q;
        acc_load = 1'b1;
        if (ir_q == OpAdd) begin
          alu_op = AluAdd;
        end else if (ir_q == OpSub) begin
          alu_op = AluSub;
        end else begin
          alu_op = AluPass;
        end
        state_d = StF0;
      end
      StSt: begin
        address = opr_q;
        write   = 1'b1;
        state_d = StF0;
      end
      StHalt: halted = 1'b1;
      default: state_d = StF0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StF0;
      pc_q    <= RESET_PC;
      ir_q    <= 4'h0;
      opr_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opr_q   <= opr_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: small programs run against a memory/accumulator model,
// per-cycle expected strobes held in a table and checked through a scoreboard queue.
module tb_cpu_control_unit;

  logic       clk;
  logic       reset;
  logic [7:0] from_memory;
  logic       zero;
  logic [7:0] address;
  logic       write;
  logic       acc_load;
  logic [1:0] alu_op;
  logic [7:0] pc;
  logic       halted;
  logic       illegal;

  cpu_control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .from_memory (from_memory),
    .zero        (zero),
    .address     (address),
    .write       (write),
    .acc_load    (acc_load),
    .alu_op      (alu_op),
    .pc          (pc),
    .halted      (halted),
    .illegal     (illegal)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic       wr;
    logic       ld;
    logic [1:0] op;
    logic       hlt;
    logic       ill;
    logic [7:0] pc;
  } vec_t;

  logic [7:0] mem [256];
  logic [7:0] acc;
  vec_t       tbl[$];
  vec_t       exp_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

`ifdef ILLEGAL_TRAP_EN
  localparam logic TrapOn = 1'b1;
`else
  localparam logic TrapOn = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory and the accumulator side of the datapath.
  always @(posedge clk) begin
    if (write) mem[address] <= acc;
    from_memory <= mem[address];
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= 8'h00;
    end else if (acc_load) begin
      case (alu_op)
        2'b00:   acc <= from_memory;
        2'b01:   acc <= acc + from_memory;
        2'b10:   acc <= acc - from_memory;
        default: acc <= 8'hXX;
      endcase
    end
  end

  assign zero = (acc == 8'h00);

  task automatic add(input logic [7:0] a, input logic [7:0] p, input logic wr, input logic ld,
                     input logic [1:0] op, input logic h, input logic il = 1'b0);
    vec_t v;
    v = '{addr: a, wr: wr, ld: ld, op: op, hlt: h, ill: il, pc: p};
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int cyc, input vec_t e);
    vec_t got;
    got = {address, write, acc_load, alu_op, halted, illegal, pc};
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s cyc%0d: got addr=%h wr=%b ld=%b op=%b hlt=%b ill=%b pc=%h, want addr=%h wr=%b ld=%b op=%b hlt=%b ill=%b pc=%h",
               nm, cyc, got.addr, got.wr, got.ld, got.op, got.hlt, got.ill, got.pc,
               e.addr, e.wr, e.ld, e.op, e.hlt, e.ill, e.pc);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
  endtask

  // Reset, release on a falling edge, then compare one table entry per cycle.
  task automatic run(input string nm);
    vec_t e;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (i > 0) @(negedge clk);
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q.pop_front();
      check(nm, i + 1, e);
    end
  endtask

  task automatic prog_c_trace(input int upto);
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 0, 2'b00, 0);
    add(8'h10, 8'h02, 0, 0, 2'b00, 0); add(8'h10, 8'h02, 0, 1, 2'b00, 0);
    add(8'h02, 8'h02, 0, 0, 2'b00, 0); add(8'h02, 8'h02, 0, 0, 2'b00, 0);
    add(8'h03, 8'h03, 0, 0, 2'b00, 0); add(8'h03, 8'h03, 0, 0, 2'b00, 0);
    add(8'h11, 8'h04, 0, 0, 2'b00, 0); add(8'h11, 8'h04, 0, 1, 2'b01, 0);
    add(8'h04, 8'h04, 0, 0, 2'b00, 0); add(8'h04, 8'h04, 0, 0, 2'b00, 0);
    add(8'h05, 8'h05, 0, 0, 2'b00, 0); add(8'h05, 8'h05, 0, 0, 2'b00, 0);
    add(8'h12, 8'h06, 1, 0, 2'b00, 0);
    add(8'h06, 8'h06, 0, 0, 2'b00, 0); add(8'h06, 8'h06, 0, 0, 2'b00, 0);
    add(8'h07, 8'h07, 0, 0, 2'b00, 1);
    while (tbl.size() > upto) void'(tbl.pop_back());
  endtask

  initial begin
    vec_t rst_v;
    rst_v = '{addr: 8'h00, wr: 0, ld: 0, op: 2'b00, hlt: 0, ill: 0, pc: 8'h00};
    reset = 1'b1;
    clear_mem();
    #12;
    check("reset_state", 0, rst_v);

    // NOP then HLT
    clear_mem(); mem[8'h00] <= 8'h00; mem[8'h01] <= 8'hF0;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 0, 2'b00, 0);
    add(8'h02, 8'h02, 0, 0, 2'b00, 1); add(8'h02, 8'h02, 0, 0, 2'b00, 1);
    run("nop_hlt");

    // LDI 2A
    clear_mem(); mem[8'h00] <= 8'h70; mem[8'h01] <= 8'h2A; mem[8'h02] <= 8'hF0;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 1, 2'b00, 0);
    add(8'h02, 8'h02, 0, 0, 2'b00, 0); add(8'h02, 8'h02, 0, 0, 2'b00, 0);
    add(8'h03, 8'h03, 0, 0, 2'b00, 1);
    run("ldi");
    n_tests++;
    if (acc !== 8'h2A) begin
      n_fail++;
      $display("FAIL ldi_acc: got %h want 2a", acc);
    end

    // LDA 10 / ADD 11 / STA 12 / HLT
    clear_mem();
    mem[8'h00] <= 8'h10; mem[8'h01] <= 8'h10; mem[8'h02] <= 8'h30; mem[8'h03] <= 8'h11;
    mem[8'h04] <= 8'h20; mem[8'h05] <= 8'h12; mem[8'h06] <= 8'hF0;
    mem[8'h10] <= 8'h05; mem[8'h11] <= 8'h07;
    prog_c_trace(20);
    run("lda_add_sta");
    n_tests++;
    if (mem[8'h12] !== 8'h0C) begin
      n_fail++;
      $display("FAIL sta_data: got %h want 0c", mem[8'h12]);
    end

    // Same program, reset hits in the ST cycle
    mem[8'h12] <= 8'h00;
    prog_c_trace(17);
    run("pre_abort");
    reset = 1'b1;
    #1;
    check("abort_in_st", 0, rst_v);
    prog_c_trace(3);
    run("restart");
    n_tests++;
    if (mem[8'h12] !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_no_write: got %h want 00", mem[8'h12]);
    end

    // JZ 40 taken (acc zero after reset)
    clear_mem(); mem[8'h00] <= 8'h60; mem[8'h01] <= 8'h40; mem[8'h40] <= 8'hF0;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 0, 2'b00, 0);
    add(8'h40, 8'h40, 0, 0, 2'b00, 0); add(8'h40, 8'h40, 0, 0, 2'b00, 0);
    add(8'h41, 8'h41, 0, 0, 2'b00, 1);
    run("jz_taken");

    // LDI 05, JZ 40 not taken
    clear_mem();
    mem[8'h00] <= 8'h70; mem[8'h01] <= 8'h05; mem[8'h02] <= 8'h60; mem[8'h03] <= 8'h40;
    mem[8'h04] <= 8'hF0; mem[8'h40] <= 8'h00;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 1, 2'b00, 0);
    add(8'h02, 8'h02, 0, 0, 2'b00, 0); add(8'h02, 8'h02, 0, 0, 2'b00, 0);
    add(8'h03, 8'h03, 0, 0, 2'b00, 0); add(8'h03, 8'h03, 0, 0, 2'b00, 0);
    add(8'h04, 8'h04, 0, 0, 2'b00, 0); add(8'h04, 8'h04, 0, 0, 2'b00, 0);
    add(8'h05, 8'h05, 0, 0, 2'b00, 1);
    run("jz_not_taken");

    // JMP FE; at FE: JMP FF (operand read at FF); FF holds HLT, PC wraps to 00
    clear_mem();
    mem[8'h00] <= 8'h50; mem[8'h01] <= 8'hFE; mem[8'hFE] <= 8'h50; mem[8'hFF] <= 8'hFF;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 0, 2'b00, 0);
    add(8'hFE, 8'hFE, 0, 0, 2'b00, 0); add(8'hFE, 8'hFE, 0, 0, 2'b00, 0);
    add(8'hFF, 8'hFF, 0, 0, 2'b00, 0); add(8'hFF, 8'hFF, 0, 0, 2'b00, 0);
    add(8'hFF, 8'hFF, 0, 0, 2'b00, 0); add(8'hFF, 8'hFF, 0, 0, 2'b00, 0);
    add(8'h00, 8'h00, 0, 0, 2'b00, 1);
    run("jmp_wrap");

    // Illegal opcode 9x
    clear_mem(); mem[8'h00] <= 8'h93; mem[8'h01] <= 8'hF0;
    tbl.delete();
    add(8'h00, 8'h00, 0, 0, 2'b00, 0); add(8'h00, 8'h00, 0, 0, 2'b00, 0);
    if (TrapOn) begin
      add(8'h01, 8'h01, 0, 0, 2'b00, 1, 1); add(8'h01, 8'h01, 0, 0, 2'b00, 1, 1);
    end else begin
      add(8'h01, 8'h01, 0, 0, 2'b00, 0); add(8'h01, 8'h01, 0, 0, 2'b00, 0);
      add(8'h02, 8'h02, 0, 0, 2'b00, 1);
    end
    run("illegal_op");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
